// File: rtl/imu_poll_seq.sv
// IMU polling sequencer: configures the gyro over an SPI monarch after power-up, then reads yaw rate on each data-ready edge.
// Optional macro FAST_SIM_EN shortens the power-up wait to a 10-bit timer for simulation.
module imu_poll_seq #(
  parameter int INIT_WAIT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld
);

`ifdef FAST_SIM_EN
  localparam int TMR_W = 10;
`else
  localparam int TMR_W = INIT_WAIT_W;
`endif

  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_MAX - TMR_W'(1);

  localparam logic [15:0] CMD_INT_CFG = 16'h0D02;
  localparam logic [15:0] CMD_ACC_CFG = 16'h1160;
  localparam logic [15:0] CMD_GYR_CFG = 16'h1440;
  localparam logic [15:0] CMD_RD_YAWL = 16'hA600;
  localparam logic [15:0] CMD_RD_YAWH = 16'hA700;

  typedef enum logic [2:0] {
    INIT_WAIT,
    WR_INT,
    WR_ACC,
    WR_GYR,
    WAIT_INT,
    RD_L,
    RD_H
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             int_s1, int_s2, int_s3;
  logic             done_q;
  logic [7:0]       yaw_lo;

  logic int_rise;
  logic done_rise;
  logic unused_rd_hi;

  // int_s3 only remembers the previous synchronized level for edge detection.
  assign int_rise     = int_s2 & ~int_s3;
  assign done_rise    = done & ~done_q;
  assign unused_rd_hi = ^rd_data[15:8];

  // NOTE: every register here is state, so all assignments are non-blocking;
  // reads within the block therefore see the value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT_WAIT;
      timer  <= '0;
      int_s1 <= 1'b0;
      int_s2 <= 1'b0;
      int_s3 <= 1'b0;
      done_q <= 1'b0;
      wrt    <= 1'b0;
      cmd    <= 16'h0000;
      yaw_lo <= 8'h00;
      yaw_rt <= 16'h0000;
      vld    <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
      int_s3 <= int_s2;
      done_q <= done;
      wrt    <= 1'b0;
      vld    <= 1'b0;

      case (state)
        // Fire on the edge where the timer reaches all-ones; it then parks there.
        INIT_WAIT: begin
          if (timer == TMR_FIRE) begin
            timer <= TMR_MAX;
            cmd   <= CMD_INT_CFG;
            wrt   <= 1'b1;
            state <= WR_INT;
          end else if (timer != TMR_MAX) begin
            timer <= timer + TMR_W'(1);
          end
        end
        WR_INT: begin
          if (done_rise) begin
            cmd   <= CMD_ACC_CFG;
            wrt   <= 1'b1;
            state <= WR_ACC;
          end
        end
        WR_ACC: begin
          if (done_rise) begin
            cmd   <= CMD_GYR_CFG;
            wrt   <= 1'b1;
            state <= WR_GYR;
          end
        end
        WR_GYR: begin
          if (done_rise) state <= WAIT_INT;
        end
        WAIT_INT: begin
          if (int_rise) begin
            cmd   <= CMD_RD_YAWL;
            wrt   <= 1'b1;
            state <= RD_L;
          end
        end
        RD_L: begin
          if (done_rise) begin
            yaw_lo <= rd_data[7:0];
            cmd    <= CMD_RD_YAWH;
            wrt    <= 1'b1;
            state  <= RD_H;
          end
        end
        // yaw_rt is only written here, so both bytes always come from one read pair.
        RD_H: begin
          if (done_rise) begin
            yaw_rt <= {rd_data[7:0], yaw_lo};
            vld    <= 1'b1;
            state  <= WAIT_INT;
          end
        end
        default: state <= INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_poll_seq.sv
// Directed bench for imu_poll_seq: a simple SPI monarch model answers each frame 40 cycles after wrt.
module tb_imu_poll_seq;

  localparam int TB_W = 8;
`ifdef FAST_SIM_EN
  localparam int WAIT_CYC = 1023;
`else
  localparam int WAIT_CYC = (1 << TB_W) - 1;
`endif
  localparam int DONE_DLY = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_in = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] yaw_rt;
  logic        vld;

  int n_checks = 0;
  int n_fail   = 0;

  bit          model_en = 1'b0;
  bit          pend     = 1'b0;
  bit          wrt_prev = 1'b0;
  int          dcnt     = 0;
  logic [15:0] rd_q[$];

  imu_poll_seq #(.INIT_WAIT_W(TB_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .INT    (int_in),
    .done   (done),
    .rd_data(rd_data),
    .wrt    (wrt),
    .cmd    (cmd),
    .yaw_rt (yaw_rt),
    .vld    (vld)
  );

  always #5 clk = ~clk;

  // SPI monarch model: drops done on wrt, raises it DONE_DLY cycles later with the next queued word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_en) begin
        if (wrt) begin
          n_checks++;
          if (pend || wrt_prev) begin
            n_fail++;
            $display("FAIL wrt_protocol: frame_outstanding=%0b wrt_prev=%0b, required 0 and 0", pend, wrt_prev);
          end
          done = 1'b0;
          pend = 1'b1;
          dcnt = 0;
        end else if (pend) begin
          dcnt++;
          if (dcnt == DONE_DLY) begin
            rd_data = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0000;
            done    = 1'b1;
            pend    = 1'b0;
          end
        end
      end
      wrt_prev = wrt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_wrt(input int max_cyc, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max_cyc && !ok) begin
      tick(1);
      n++;
      if (wrt) ok = 1'b1;
    end
  endtask

  task automatic wait_vld(input int max_cyc, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max_cyc && !ok) begin
      tick(1);
      n++;
      if (vld) ok = 1'b1;
    end
  endtask

  task automatic count_wrt(input int cyc, output int cnt);
    cnt = 0;
    repeat (cyc) begin
      tick(1);
      if (wrt) cnt++;
    end
  endtask

  task automatic count_vld(input int cyc, output int cnt);
    cnt = 0;
    repeat (cyc) begin
      tick(1);
      if (vld) cnt++;
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    model_en = 1'b1;
    tick(3);
    n_checks++;
    if (wrt !== 1'b0) begin n_fail++; $display("FAIL reset_wrt: got %0b, required 0", wrt); end
    n_checks++;
    if (cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd: got %h, required 0000", cmd); end
    n_checks++;
    if (yaw_rt !== 16'h0000) begin n_fail++; $display("FAIL reset_yaw: got %h, required 0000", yaw_rt); end
    n_checks++;
    if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %0b, required 0", vld); end
  endtask

  task automatic test_init_wait;
    int n;
    bit ok;
    int cnt;
    rst = 1'b0;
    wait_wrt(WAIT_CYC + 20, n, ok);
    n_checks++;
    if (!ok || n != WAIT_CYC) begin n_fail++; $display("FAIL init_wait_len: got %0d ok=%0b, required %0d", n, ok, WAIT_CYC); end
    n_checks++;
    if (cmd !== 16'h0D02) begin n_fail++; $display("FAIL init_cmd0: got %h, required 0D02", cmd); end
    wait_wrt(100, n, ok);
    n_checks++;
    if (!ok || n != DONE_DLY + 1) begin n_fail++; $display("FAIL init_gap1: got %0d ok=%0b, required %0d", n, ok, DONE_DLY + 1); end
    n_checks++;
    if (cmd !== 16'h1160) begin n_fail++; $display("FAIL init_cmd1: got %h, required 1160", cmd); end
    wait_wrt(100, n, ok);
    n_checks++;
    if (!ok || cmd !== 16'h1440) begin n_fail++; $display("FAIL init_cmd2: got %h ok=%0b, required 1440", cmd, ok); end
    count_wrt(300, cnt);
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL init_idle: got %0d wrt pulses, required 0", cnt); end
  endtask

  task automatic test_read;
    int n;
    bit ok;
    rd_q.push_back(16'hAB34);
    rd_q.push_back(16'hCD12);
    int_in = 1'b1;
    wait_wrt(10, n, ok);
    n_checks++;
    if (!ok || n != 3) begin n_fail++; $display("FAIL int_latency: got %0d ok=%0b, required 3", n, ok); end
    n_checks++;
    if (cmd !== 16'hA600) begin n_fail++; $display("FAIL read_cmd_lo: got %h, required A600", cmd); end
    tick(2);
    int_in = 1'b0;
    wait_wrt(100, n, ok);
    n_checks++;
    if (!ok || cmd !== 16'hA700) begin n_fail++; $display("FAIL read_cmd_hi: got %h ok=%0b, required A700", cmd, ok); end
    n_checks++;
    if (yaw_rt !== 16'h0000) begin n_fail++; $display("FAIL read_yaw_hold: got %h, required 0000", yaw_rt); end
    wait_vld(100, n, ok);
    n_checks++;
    if (!ok || n != DONE_DLY + 1) begin n_fail++; $display("FAIL read_vld_time: got %0d ok=%0b, required %0d", n, ok, DONE_DLY + 1); end
    n_checks++;
    if (yaw_rt !== 16'h1234) begin n_fail++; $display("FAIL read_yaw: got %h, required 1234", yaw_rt); end
    tick(1);
    n_checks++;
    if (vld !== 1'b0 || yaw_rt !== 16'h1234) begin
      n_fail++; $display("FAIL read_vld_width: got vld=%0b yaw=%h, required 0 and 1234", vld, yaw_rt);
    end
  endtask

  task automatic test_int_drop;
    int n;
    bit ok;
    int cnt;
    rd_q.push_back(16'hFF78);
    rd_q.push_back(16'h0156);
    int_in = 1'b1;
    wait_wrt(10, n, ok);
    n_checks++;
    if (!ok || cmd !== 16'hA600) begin n_fail++; $display("FAIL drop_cmd_lo: got %h ok=%0b, required A600", cmd, ok); end
    tick(10);
    int_in = 1'b0;
    tick(2);
    int_in = 1'b1;
    tick(3);
    int_in = 1'b0;
    wait_wrt(100, n, ok);
    n_checks++;
    if (!ok || cmd !== 16'hA700) begin n_fail++; $display("FAIL drop_cmd_hi: got %h ok=%0b, required A700", cmd, ok); end
    wait_vld(100, n, ok);
    n_checks++;
    if (!ok || yaw_rt !== 16'h5678) begin n_fail++; $display("FAIL drop_yaw: got %h ok=%0b, required 5678", yaw_rt, ok); end
    count_wrt(200, cnt);
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL drop_no_extra: got %0d wrt pulses, required 0", cnt); end
    rd_q.push_back(16'h009A);
    rd_q.push_back(16'h00BC);
    int_in = 1'b1;
    wait_wrt(10, n, ok);
    n_checks++;
    if (!ok || n != 3 || cmd !== 16'hA600) begin
      n_fail++; $display("FAIL next_read_lo: got n=%0d cmd=%h ok=%0b, required 3 and A600", n, cmd, ok);
    end
    int_in = 1'b0;
    wait_wrt(100, n, ok);
    wait_vld(100, n, ok);
    n_checks++;
    if (!ok || yaw_rt !== 16'hBC9A) begin n_fail++; $display("FAIL next_read_yaw: got %h ok=%0b, required BC9A", yaw_rt, ok); end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    bit ok;
    rd_q.push_back(16'h0011);
    rd_q.push_back(16'h0022);
    int_in = 1'b1;
    wait_wrt(10, n, ok);
    int_in = 1'b0;
    wait_wrt(100, n, ok);
    n_checks++;
    if (!ok || cmd !== 16'hA700) begin n_fail++; $display("FAIL midrst_setup: got %h ok=%0b, required A700", cmd, ok); end
    tick(10);
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (wrt !== 1'b0 || cmd !== 16'h0000 || vld !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got wrt=%0b cmd=%h vld=%0b, required 0 0000 0", wrt, cmd, vld);
    end
    n_checks++;
    if (yaw_rt !== 16'h0000) begin n_fail++; $display("FAIL midrst_yaw: got %h, required 0000", yaw_rt); end
    rst = 1'b0;
    wait_wrt(WAIT_CYC + 20, n, ok);
    n_checks++;
    if (!ok || n != WAIT_CYC || cmd !== 16'h0D02) begin
      n_fail++; $display("FAIL midrst_restart: got n=%0d cmd=%h ok=%0b, required %0d and 0D02", n, cmd, ok, WAIT_CYC);
    end
    wait_wrt(100, n, ok);
    n_checks++;
    if (!ok || cmd !== 16'h1160) begin n_fail++; $display("FAIL midrst_cmd1: got %h ok=%0b, required 1160", cmd, ok); end
    wait_wrt(100, n, ok);
    n_checks++;
    if (!ok || cmd !== 16'h1440) begin n_fail++; $display("FAIL midrst_cmd2: got %h ok=%0b, required 1440", cmd, ok); end
    tick(60);
  endtask

  task automatic test_done_hold;
    int n;
    bit ok;
    int cnt;
    model_en = 1'b0;
    done = 1'b0;
    tick(1);
    done = 1'b1;
    count_wrt(20, cnt);
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL hold_wait_int: got %0d wrt pulses, required 0", cnt); end
    int_in = 1'b1;
    wait_wrt(10, n, ok);
    n_checks++;
    if (!ok || n != 3 || cmd !== 16'hA600) begin
      n_fail++; $display("FAIL hold_cmd_lo: got n=%0d cmd=%h ok=%0b, required 3 and A600", n, cmd, ok);
    end
    int_in = 1'b0;
    count_wrt(60, cnt);
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL hold_rd_l: got %0d wrt pulses, required 0", cnt); end
    rd_data = 16'h0011;
    done = 1'b0;
    tick(1);
    done = 1'b1;
    wait_wrt(5, n, ok);
    n_checks++;
    if (!ok || n != 1 || cmd !== 16'hA700) begin
      n_fail++; $display("FAIL hold_cmd_hi: got n=%0d cmd=%h ok=%0b, required 1 and A700", n, cmd, ok);
    end
    count_vld(60, cnt);
    n_checks++;
    if (cnt != 0 || yaw_rt !== 16'h0000) begin
      n_fail++; $display("FAIL hold_rd_h: got vld_pulses=%0d yaw=%h, required 0 and 0000", cnt, yaw_rt);
    end
    rd_data = 16'h0022;
    done = 1'b0;
    tick(1);
    done = 1'b1;
    wait_vld(5, n, ok);
    n_checks++;
    if (!ok || n != 1 || yaw_rt !== 16'h2211) begin
      n_fail++; $display("FAIL hold_yaw: got n=%0d yaw=%h ok=%0b, required 1 and 2211", n, yaw_rt, ok);
    end
  endtask

  initial begin
    test_reset();
    test_init_wait();
    test_read();
    test_int_drop();
    test_reset_mid_frame();
    test_done_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imu_poll_seq.md
IMU_POLL_SEQ -- requirements
Module: imu_poll_seq

Interface
REQ-001 Parameter: INIT_WAIT_W, default 16, width of the power-up wait timer.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 INT  input  1  sensor data-ready line; asynchronous to clk.
REQ-006 done  input  1  SPI monarch transaction-complete level; goes high at end of frame and stays high until the next wrt.
REQ-007 rd_data  input  16  SPI monarch received word; valid when done rises.
REQ-008 wrt  output  1  one-cycle registered pulse that starts an SPI frame.
REQ-009 cmd  output  16  SPI command word, registered and stable from wrt until the matching done edge.
REQ-010 yaw_rt  output  16  latest yaw-rate sample, {high byte, low byte}.
REQ-011 vld  output  1  one-cycle pulse when yaw_rt updates.

Function
REQ-012 INT SHALL pass through a two-flop synchronizer; the block SHALL act only on a rising edge of the synchronized INT.
REQ-013 done SHALL be edge-detected: done_rise = done & ~done_q, where done_q is done registered one cycle.
REQ-014 States SHALL be: INIT_WAIT, WR_INT, WR_ACC, WR_GYR, WAIT_INT, RD_L, RD_H.
REQ-015 INIT_WAIT: count an INIT_WAIT_W-bit timer from 0; on the all-ones value, set cmd=0x0D02, pulse wrt, and go to WR_INT.
REQ-016 WR_INT: on done_rise, set cmd=0x1160, pulse wrt, and go to WR_ACC.
REQ-017 WR_ACC: on done_rise, set cmd=0x1440, pulse wrt, and go to WR_GYR.
REQ-018 WR_GYR: on done_rise, go to WAIT_INT with no wrt.
REQ-019 WAIT_INT: on a synchronized INT rising edge, set cmd=0xA600, pulse wrt, and go to RD_L.
REQ-020 RD_L: on done_rise, latch rd_data[7:0] into the low byte, set cmd=0xA700, pulse wrt, and go to RD_H.
REQ-021 RD_H: on done_rise, latch rd_data[7:0] into the high byte, update yaw_rt, and go to WAIT_INT.
REQ-022 RD_H: vld SHALL be high on the same cycle yaw_rt takes its new value (one clock after done_rise).
REQ-023 wrt SHALL be high on exactly one cycle per frame, and never while a frame is outstanding.
REQ-024 A done_rise while in INIT_WAIT or WAIT_INT SHALL be ignored.
REQ-025 An INT edge outside WAIT_INT SHALL be dropped, not queued.
REQ-026 The init timer SHALL stop at all-ones and SHALL not wrap.
REQ-027 Latency: wrt is asserted one cycle after the synchronized INT rising edge is detected, i.e. three clocks after INT rises.
REQ-028 yaw_rt SHALL hold its value between updates; the high and low bytes SHALL never be mixed from different INT events.

Reset
REQ-029 rst high at any clock edge SHALL force: state=INIT_WAIT, timer=0, wrt=0, cmd=0x0000, yaw_rt=0x0000, vld=0, synchronizer and done_q=0.
REQ-030 Reset mid-frame SHALL abandon the frame; the block SHALL not wait for its done before restarting the init sequence.

Configuration
REQ-031 Macro FAST_SIM_EN: when defined, the init timer SHALL be 10 bits wide (1023-cycle wait), overriding INIT_WAIT_W.
REQ-032 Without FAST_SIM_EN, the init timer SHALL be INIT_WAIT_W bits wide (65535 cycles at the default width).
REQ-033 All other behaviour SHALL be identical with and without FAST_SIM_EN.

Verification
REQ-034 Release rst, with FAST_SIM_EN defined -> first wrt exactly 1023 cycles later with cmd=0x0D02; no wrt before that.
REQ-035 Model done rising 40 cycles after each wrt -> wrts carry 0x0D02, 0x1160, 0x1440 in order, then the block idles in WAIT_INT.
REQ-036 In WAIT_INT, raise INT; return rd_data=0x0034, then 0x0012 -> cmd=0xA600 then 0xA700, yaw_rt=0x1234, vld high exactly one cycle.
REQ-037 Pulse INT during the RD_L frame -> no extra frame; next INT after return to WAIT_INT -> a new read pair.
REQ-038 Assert rst during the RD_H frame -> all outputs zero next cycle, yaw_rt=0x0000, init sequence restarts from the timer.
REQ-039 Hold done high across states without a new wrt -> no spurious transitions; only 0-to-1 edges advance the FSM.
